// File: rtl/match_frame_sequencer.sv
// match_frame_sequencer
// Frame-level controller: for each set it runs the template handler, then the
// window handler, collects the NCC result and writes it back as RESULT_WORDS
// words through a req/gnt memory port. Optionally skips low-score sets.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start; cfg latched when start is accepted
// TEMP     | template handler enabled, template reads in flight
// WIND     | window handler enabled, window reads in flight
// WAIT_RES | window done, waiting for the NCC result
// WRITE    | writing packed result word k, held while mem_gnt is low
// NEXT     | advance set index, decide next set or end of frame
// DONE     | one-cycle frame_done pulse
module match_frame_sequencer #(
  parameter int DATA_W       = 32,
  parameter int COORD_W      = 7,
  parameter int NCC_W        = 64,
  parameter int IDX_W        = 13,
  parameter int RESULT_WORDS = 3,
  parameter int SET_W        = 8,
  localparam int WI_W        = (RESULT_WORDS > 1) ? $clog2(RESULT_WORDS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [SET_W-1:0]   i_cfg_num_sets,
  input  logic               i_cfg_skip_low,
  input  logic [NCC_W-1:0]   i_cfg_thresh,
  output logic               o_tmpl_en,
  input  logic               i_tmpl_done,
  input  logic [COORD_W-1:0] i_tmpl_row,
  input  logic [COORD_W-1:0] i_tmpl_col,
  output logic               o_win_en,
  input  logic               i_win_done,
  input  logic [COORD_W-1:0] i_win_row,
  input  logic [COORD_W-1:0] i_win_col,
  input  logic               i_ncc_valid,
  input  logic [NCC_W-1:0]   i_ncc_score,
  input  logic [IDX_W-1:0]   i_ncc_index,
  output logic               o_mem_req,
  input  logic               i_mem_gnt,
  output logic               o_mem_rd_wr,
  output logic               o_mem_sel,
  output logic [COORD_W-1:0] o_mem_row,
  output logic [COORD_W-1:0] o_mem_col,
  output logic [DATA_W-1:0]  o_mem_wdata,
  output logic [WI_W-1:0]    o_mem_wr_index,
  output logic [SET_W-1:0]   o_set_idx,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_frame_aborted,
  output logic [SET_W-1:0]   o_skip_count
);

  localparam int PACK_W = RESULT_WORDS * DATA_W;
  localparam int PAD_W  = PACK_W - NCC_W - IDX_W;
  localparam logic [WI_W-1:0] K_LAST = WI_W'(RESULT_WORDS - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_TEMP     = 3'd1;
  localparam logic [2:0] S_WIND     = 3'd2;
  localparam logic [2:0] S_WAIT_RES = 3'd3;
  localparam logic [2:0] S_WRITE    = 3'd4;
  localparam logic [2:0] S_NEXT     = 3'd5;
  localparam logic [2:0] S_DONE     = 3'd6;

  // The packed result must fit in the write-back words.
  if (NCC_W + IDX_W > PACK_W) begin : g_cfg_check
    $error("match_frame_sequencer: NCC_W+IDX_W exceeds RESULT_WORDS*DATA_W");
  end

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [WI_W-1:0]   r_k;
  logic [PACK_W-1:0] r_result;
  logic [SET_W-1:0]  r_set_idx;
  logic [SET_W-1:0]  r_skip_count;
  logic [SET_W-1:0]  r_num_sets;
  logic              r_skip_low;
  logic [NCC_W-1:0]  r_thresh;
  logic              r_aborted;
  logic              r_have_res;
  logic              r_res_skip;

  logic [PACK_W-1:0] w_packed;
  logic              w_low;
  logic              w_abort;
  logic              w_decide;
  logic              w_dec_skip;
  logic [SET_W-1:0]  w_set_inc;
  logic [SET_W-1:0]  w_skip_sat;

  // Score, index, then zero pad down to bit 0.
  assign w_packed   = PACK_W'({i_ncc_score, i_ncc_index}) << PAD_W;
  assign w_low      = r_skip_low && ($signed(i_ncc_score) < $signed(r_thresh));
  assign w_abort    = i_abort && (r_state != S_IDLE);
  assign w_set_inc  = r_set_idx + SET_W'(1);
  assign w_skip_sat = (r_skip_count == '1) ? r_skip_count : r_skip_count + SET_W'(1);

  // A result may have arrived earlier in WIND (r_have_res) or arrive with win_done.
  assign w_decide   = ((r_state == S_WIND) && i_win_done && (i_ncc_valid || r_have_res)) ||
                      ((r_state == S_WAIT_RES) && i_ncc_valid);
  assign w_dec_skip = i_ncc_valid ? w_low : r_res_skip;

  // Next-state decode; abort overrides every other transition outside IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:     if (i_start) w_state_nxt = (i_cfg_num_sets == '0) ? S_DONE : S_TEMP;
      S_TEMP:     if (i_tmpl_done) w_state_nxt = S_WIND;
      S_WIND: begin
        if (i_win_done) begin
          if (w_decide) w_state_nxt = w_dec_skip ? S_NEXT : S_WRITE;
          else          w_state_nxt = S_WAIT_RES;
        end
      end
      S_WAIT_RES: if (i_ncc_valid) w_state_nxt = w_low ? S_NEXT : S_WRITE;
      S_WRITE:    if (i_mem_gnt && (r_k == K_LAST)) w_state_nxt = S_NEXT;
      S_NEXT:     w_state_nxt = (w_set_inc == r_num_sets) ? S_DONE : S_TEMP;
      S_DONE:     w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
    if (w_abort) w_state_nxt = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Config latch, set/skip counters, result capture and write-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k          <= '0;
      r_result     <= '0;
      r_set_idx    <= '0;
      r_skip_count <= '0;
      r_num_sets   <= '0;
      r_skip_low   <= 1'b0;
      r_thresh     <= '0;
      r_aborted    <= 1'b0;
      r_have_res   <= 1'b0;
      r_res_skip   <= 1'b0;
    end else begin
      r_aborted <= w_abort;
      if (w_abort) begin
        r_k        <= '0;
        r_have_res <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start) begin
              r_num_sets   <= i_cfg_num_sets;
              r_skip_low   <= i_cfg_skip_low;
              r_thresh     <= i_cfg_thresh;
              r_set_idx    <= '0;
              r_skip_count <= '0;
              r_k          <= '0;
              r_have_res   <= 1'b0;
            end
          end
          S_WIND: begin
            if (i_ncc_valid) begin
              r_result   <= w_packed;
              r_have_res <= 1'b1;
              r_res_skip <= w_low;
            end
            if (w_decide) begin
              r_have_res <= 1'b0;
              if (w_dec_skip) r_skip_count <= w_skip_sat;
            end
          end
          S_WAIT_RES: begin
            if (i_ncc_valid) begin
              r_result <= w_packed;
              if (w_low) r_skip_count <= w_skip_sat;
            end
          end
          S_WRITE: begin
            if (i_mem_gnt) r_k <= (r_k == K_LAST) ? '0 : r_k + WI_W'(1);
          end
          S_NEXT:  r_set_idx <= w_set_inc;
          default: ;
        endcase
      end
    end
  end

  // Moore output decode; addresses are state-selected handler addresses.
  always_comb begin
    o_tmpl_en       = 1'b0;
    o_win_en        = 1'b0;
    o_mem_req       = 1'b0;
    o_mem_rd_wr     = 1'b0;
    o_mem_sel       = 1'b0;
    o_mem_row       = '0;
    o_mem_col       = '0;
    o_mem_wdata     = '0;
    o_mem_wr_index  = '0;
    o_busy          = 1'b0;
    o_frame_done    = 1'b0;
    o_frame_aborted = r_aborted;
    o_set_idx       = r_set_idx;
    o_skip_count    = r_skip_count;
    case (r_state)
      S_TEMP: begin
        o_busy    = 1'b1;
        o_tmpl_en = 1'b1;
        o_mem_req = 1'b1;
        o_mem_row = i_tmpl_row;
        o_mem_col = i_tmpl_col;
      end
      S_WIND: begin
        o_busy    = 1'b1;
        o_win_en  = 1'b1;
        o_mem_req = 1'b1;
        o_mem_sel = 1'b1;
        o_mem_row = i_win_row;
        o_mem_col = i_win_col;
      end
      S_WAIT_RES: o_busy = 1'b1;
      S_WRITE: begin
        o_busy         = 1'b1;
        o_mem_req      = 1'b1;
        o_mem_rd_wr    = 1'b1;
        o_mem_wr_index = r_k;
        o_mem_wdata    = DATA_W'(r_result >> (int'(r_k) * DATA_W));
      end
      S_NEXT:  o_busy = 1'b1;
      S_DONE:  o_frame_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_match_frame_sequencer.sv
// Randomized bench for match_frame_sequencer. Two instances (3-word and
// 4-word result) share stimulus; sel4 picks which one is driven and observed.
module tb_match_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, sel4;
  logic [7:0]  cfg_num_sets;
  logic        cfg_skip_low;
  logic [63:0] cfg_thresh;
  logic        tmpl_done, win_done, ncc_valid, mem_gnt;
  logic [6:0]  tmpl_row, tmpl_col, win_row, win_col;
  logic [63:0] ncc_score;
  logic [12:0] ncc_index;

  logic start_a, start_b, abort_a, abort_b;
  assign start_a = start & ~sel4;
  assign start_b = start & sel4;
  assign abort_a = abort & ~sel4;
  assign abort_b = abort & sel4;

  logic       a_tmpl_en, a_win_en, a_mem_req, a_mem_rd_wr, a_mem_sel, a_busy, a_frame_done, a_frame_aborted;
  logic [6:0] a_mem_row, a_mem_col;
  logic [31:0] a_mem_wdata;
  logic [1:0] a_mem_wr_index;
  logic [7:0] a_set_idx, a_skip_count;
  logic       b_tmpl_en, b_win_en, b_mem_req, b_mem_rd_wr, b_mem_sel, b_busy, b_frame_done, b_frame_aborted;
  logic [6:0] b_mem_row, b_mem_col;
  logic [31:0] b_mem_wdata;
  logic [1:0] b_mem_wr_index;
  logic [7:0] b_set_idx, b_skip_count;

  logic       m_tmpl_en, m_win_en, m_mem_req, m_mem_rd_wr, m_mem_sel, m_busy, m_frame_done, m_frame_aborted;
  logic [6:0] m_mem_row, m_mem_col;
  logic [31:0] m_mem_wdata;
  logic [1:0] m_mem_wr_index;
  logic [7:0] m_set_idx, m_skip_count;

  assign m_tmpl_en       = sel4 ? b_tmpl_en       : a_tmpl_en;
  assign m_win_en        = sel4 ? b_win_en        : a_win_en;
  assign m_mem_req       = sel4 ? b_mem_req       : a_mem_req;
  assign m_mem_rd_wr     = sel4 ? b_mem_rd_wr     : a_mem_rd_wr;
  assign m_mem_sel       = sel4 ? b_mem_sel       : a_mem_sel;
  assign m_busy          = sel4 ? b_busy          : a_busy;
  assign m_frame_done    = sel4 ? b_frame_done    : a_frame_done;
  assign m_frame_aborted = sel4 ? b_frame_aborted : a_frame_aborted;
  assign m_mem_row       = sel4 ? b_mem_row       : a_mem_row;
  assign m_mem_col       = sel4 ? b_mem_col       : a_mem_col;
  assign m_mem_wdata     = sel4 ? b_mem_wdata     : a_mem_wdata;
  assign m_mem_wr_index  = sel4 ? b_mem_wr_index  : a_mem_wr_index;
  assign m_set_idx       = sel4 ? b_set_idx       : a_set_idx;
  assign m_skip_count    = sel4 ? b_skip_count    : a_skip_count;

  match_frame_sequencer dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(start_a), .i_abort(abort_a),
    .i_cfg_num_sets(cfg_num_sets), .i_cfg_skip_low(cfg_skip_low), .i_cfg_thresh(cfg_thresh),
    .o_tmpl_en(a_tmpl_en), .i_tmpl_done(tmpl_done), .i_tmpl_row(tmpl_row), .i_tmpl_col(tmpl_col),
    .o_win_en(a_win_en), .i_win_done(win_done), .i_win_row(win_row), .i_win_col(win_col),
    .i_ncc_valid(ncc_valid), .i_ncc_score(ncc_score), .i_ncc_index(ncc_index),
    .o_mem_req(a_mem_req), .i_mem_gnt(mem_gnt), .o_mem_rd_wr(a_mem_rd_wr), .o_mem_sel(a_mem_sel),
    .o_mem_row(a_mem_row), .o_mem_col(a_mem_col), .o_mem_wdata(a_mem_wdata),
    .o_mem_wr_index(a_mem_wr_index), .o_set_idx(a_set_idx), .o_busy(a_busy),
    .o_frame_done(a_frame_done), .o_frame_aborted(a_frame_aborted), .o_skip_count(a_skip_count)
  );

  match_frame_sequencer #(.RESULT_WORDS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(start_b), .i_abort(abort_b),
    .i_cfg_num_sets(cfg_num_sets), .i_cfg_skip_low(cfg_skip_low), .i_cfg_thresh(cfg_thresh),
    .o_tmpl_en(b_tmpl_en), .i_tmpl_done(tmpl_done), .i_tmpl_row(tmpl_row), .i_tmpl_col(tmpl_col),
    .o_win_en(b_win_en), .i_win_done(win_done), .i_win_row(win_row), .i_win_col(win_col),
    .i_ncc_valid(ncc_valid), .i_ncc_score(ncc_score), .i_ncc_index(ncc_index),
    .o_mem_req(b_mem_req), .i_mem_gnt(mem_gnt), .o_mem_rd_wr(b_mem_rd_wr), .o_mem_sel(b_mem_sel),
    .o_mem_row(b_mem_row), .o_mem_col(b_mem_col), .o_mem_wdata(b_mem_wdata),
    .o_mem_wr_index(b_mem_wr_index), .o_set_idx(b_set_idx), .o_busy(b_busy),
    .o_frame_done(b_frame_done), .o_frame_aborted(b_frame_aborted), .o_skip_count(b_skip_count)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int last_nwr;
  logic [63:0] sc [0:255];
  logic [12:0] ix [0:255];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One frame: build the expected write stream from sc/ix, then act as the
  // handlers, NCC engine and memory arbiter cycle by cycle while checking.
  task automatic run_frame(input int nsets, input bit skl, input logic [63:0] thr,
                           input int gmode, input int fdly, input int ab_set,
                           input bit spam, input bit ab_with_start, input bit rst_wr);
    int rw, exp_skip, exp_wr, n_done, n_ab, n_wr, n_req, done_cyc;
    int tcnt, tdly, wcnt, wdly, wset, pend, stall_left;
    bit fin, ab_sent, prev_stall;
    logic [1:0]   prev_idx;
    logic [31:0]  prev_dat;
    logic [127:0] v;
    int           eq_idx[$];
    logic [31:0]  eq_dat[$];
    rw = sel4 ? 4 : 3;
    exp_skip = 0;
    for (int s = 0; s < nsets; s++) begin
      if (skl && ($signed(sc[s]) < $signed(thr))) exp_skip++;
      else begin
        v = {64'b0, sc[s]};
        v = (v << 13) | 128'(ix[s]);
        v = v << (rw * 32 - 77);
        for (int k = 0; k < rw; k++) begin
          eq_idx.push_back(k);
          eq_dat.push_back(32'(v >> (32 * k)));
        end
      end
    end
    exp_wr = eq_idx.size();
    n_done = 0; n_ab = 0; n_wr = 0; n_req = 0; done_cyc = -1;
    tcnt = 0; tdly = 1; wcnt = 0; wdly = 1; wset = 0; pend = 0; stall_left = 5;
    fin = 0; ab_sent = 0; prev_stall = 0; prev_idx = '0; prev_dat = '0;
    start = 1'b1; abort = ab_with_start;
    cfg_num_sets = 8'(nsets); cfg_skip_low = skl; cfg_thresh = thr;
    for (int cyc = 1; cyc <= 20000 && !fin; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; tmpl_done = 1'b0; win_done = 1'b0; ncc_valid = 1'b0;
      tmpl_row = 7'($urandom); tmpl_col = 7'($urandom);
      win_row = 7'($urandom); win_col = 7'($urandom);
      if (cyc == 1 && nsets > 0) begin
        check_val("start_busy", m_busy, 1);
        check_val("start_set_idx", m_set_idx, 0);
        check_val("start_skip", m_skip_count, 0);
      end
      if (m_mem_req) n_req++;
      if (m_frame_done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
        check_val("final_set_idx", m_set_idx, 64'(nsets));
        check_val("final_skip", m_skip_count, 64'(exp_skip));
        check_val("done_busy", m_busy, 0);
        fin = 1;
      end
      if (m_frame_aborted) begin
        n_ab++;
        check_val("abort_req", m_mem_req, 0);
        check_val("abort_busy", m_busy, 0);
        check_val("abort_tmpl_en", m_tmpl_en, 0);
        fin = 1;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) ncc_valid = 1'b1;
      end
      if (m_tmpl_en) begin
        if (tcnt == 0) tdly = (fdly > 0) ? fdly : $urandom_range(1, 4);
        tcnt++;
        if (tcnt == tdly) tmpl_done = 1'b1;
        else if ($urandom_range(0, 3) == 0) begin
          ncc_valid = 1'b1;
          ncc_score = {$urandom, $urandom};
        end
      end else tcnt = 0;
      if (m_win_en) begin
        if (wcnt == 0) wdly = (fdly > 0) ? fdly : $urandom_range(1, 4);
        wcnt++;
        if (wcnt == wdly) begin
          win_done = 1'b1;
          ncc_score = sc[wset & 255];
          ncc_index = ix[wset & 255];
          wset++;
          if ($urandom_range(0, 1) == 1) ncc_valid = 1'b1;
          else pend = $urandom_range(1, 3);
        end
      end else wcnt = 0;
      case (gmode)
        0: mem_gnt = 1'b1;
        1: mem_gnt = ($urandom_range(0, 2) != 0);
        default: begin
          mem_gnt = !(m_mem_req && m_mem_rd_wr && m_mem_wr_index == 2'd1 && stall_left > 0);
          if (!mem_gnt) stall_left--;
        end
      endcase
      if (m_mem_req && m_mem_rd_wr && !fin) begin
        if (prev_stall) begin
          check_val("stall_idx", m_mem_wr_index, prev_idx);
          check_val("stall_dat", m_mem_wdata, prev_dat);
        end
        if (rst_wr) begin
          rst_n = 1'b0;
          #1;
          check_val("rst_req", m_mem_req, 0);
          check_val("rst_busy", m_busy, 0);
          check_val("rst_set_idx", m_set_idx, 0);
          check_val("rst_wdata", m_mem_wdata, 0);
          fin = 1;
          prev_stall = 0;
        end else if (!ab_sent && ab_set >= 0 && int'(m_set_idx) == ab_set && m_mem_wr_index == 2'd1) begin
          abort = 1'b1;
          mem_gnt = 1'b0;
          ab_sent = 1;
          prev_stall = 0;
        end else begin
          if (mem_gnt) begin
            n_wr++;
            if (eq_idx.size() == 0) check_val("extra_write", 1, 0);
            else begin
              check_val("wr_index", m_mem_wr_index, 64'(eq_idx.pop_front()));
              check_val("wr_data", m_mem_wdata, eq_dat.pop_front());
            end
          end
          prev_stall = !mem_gnt;
          prev_idx = m_mem_wr_index;
          prev_dat = m_mem_wdata;
        end
      end else begin
        if (prev_stall) check_val("stall_req", m_mem_req & m_mem_rd_wr, 1);
        prev_stall = 0;
      end
      if (spam && m_busy && $urandom_range(0, 3) == 0) start = 1'b1;
      #1;
      if (m_tmpl_en) begin
        check_val("t_req", m_mem_req, 1);
        check_val("t_rdwr", m_mem_rd_wr, 0);
        check_val("t_sel", m_mem_sel, 0);
        check_val("t_row", m_mem_row, tmpl_row);
        check_val("t_col", m_mem_col, tmpl_col);
      end
      if (m_win_en) begin
        check_val("w_req", m_mem_req, 1);
        check_val("w_sel", m_mem_sel, 1);
        check_val("w_row", m_mem_row, win_row);
        check_val("w_col", m_mem_col, win_col);
      end
    end
    if (!fin) check_val("frame_timeout", 1, 0);
    last_nwr = n_wr;
    if (rst_wr) begin
      check_val("rst_no_done", n_done, 0);
      rst_n = 1'b1;
    end else if (ab_set >= 0) begin
      check_val("abort_count", n_ab, 1);
      check_val("abort_no_done", n_done, 0);
    end else begin
      check_val("done_count", n_done, 1);
      check_val("no_abort", n_ab, 0);
      check_val("wr_count", n_wr, 64'(exp_wr));
      check_val("wr_left", eq_idx.size(), 0);
    end
    if (nsets == 0) begin
      check_val("zero_req", n_req, 0);
      check_val("zero_latency", (done_cyc >= 1 && done_cyc <= 2), 1);
    end
    abort = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check_val("done_pulse_len", m_frame_done, 0);
    check_val("abort_pulse_len", m_frame_aborted, 0);
    #2;
  endtask

  task automatic rand_scores(input int n);
    for (int s = 0; s < n; s++) begin
      sc[s] = {$urandom, $urandom};
      ix[s] = 13'($urandom);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel4 = 1'b0;
    cfg_num_sets = '0; cfg_skip_low = 1'b0; cfg_thresh = '0;
    tmpl_done = 1'b0; win_done = 1'b0; ncc_valid = 1'b0; mem_gnt = 1'b0;
    tmpl_row = '0; tmpl_col = '0; win_row = '0; win_col = '0;
    ncc_score = '0; ncc_index = '0;
    #12;
    for (int d = 0; d < 2; d++) begin
      sel4 = (d == 1);
      #1;
      check_val("rst_busy0", m_busy, 0);
      check_val("rst_req0", m_mem_req, 0);
      check_val("rst_set0", m_set_idx, 0);
      check_val("rst_skip0", m_skip_count, 0);
      check_val("rst_flags0", {m_frame_done, m_frame_aborted, m_tmpl_en, m_win_en}, 0);
    end
    sel4 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_val("post_rst_busy", m_busy, 0);
    #2;

    // Fixed example: two sets, handlers done after 4 cycles, grant always high.
    for (int s = 0; s < 2; s++) begin
      sc[s] = 64'h0000_0001_8000_0000;
      ix[s] = 13'h1ABC;
    end
    run_frame(2, 0, 64'd0, 0, 4, -1, 0, 0, 0);

    // Five-cycle grant stall on word 1.
    rand_scores(3);
    run_frame(3, 0, 64'd0, 2, 0, -1, 0, 0, 0);

    // Skip mode, alternating -1/+1 scores against threshold 0.
    rand_scores(4);
    for (int s = 0; s < 4; s++) sc[s] = (s % 2 == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1;
    run_frame(4, 1, 64'd0, 0, 0, -1, 0, 0, 0);

    // Zero sets.
    run_frame(0, 0, 64'd0, 0, 0, -1, 0, 0, 0);

    // Abort during word 1 of set 1.
    rand_scores(3);
    run_frame(3, 0, 64'd0, 0, 0, 1, 0, 0, 0);
    check_val("abort_writes", last_nwr, 4);

    // Restart after abort, with start and abort together in IDLE.
    rand_scores(2);
    run_frame(2, 0, 64'd0, 1, 0, -1, 0, 1, 0);

    // Random frames with random skip configuration and grants.
    for (int f = 0; f < 4; f++) begin
      int n;
      n = $urandom_range(1, 6);
      rand_scores(n);
      run_frame(n, 1'($urandom), {$urandom, $urandom}, 1, 0, -1, 0, 0, 0);
    end

    // Four-word instance, 150 sets, start pulses while busy.
    sel4 = 1'b1;
    rand_scores(150);
    run_frame(150, 0, 64'd0, 1, 0, -1, 1, 0, 0);
    check_val("rw4_writes", last_nwr, 600);

    // Asynchronous reset in the middle of a write, then a clean frame.
    sel4 = 1'b0;
    rand_scores(2);
    run_frame(2, 0, 64'd0, 1, 0, -1, 0, 0, 1);
    rand_scores(1);
    run_frame(1, 0, 64'd0, 0, 0, -1, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
